// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared CAM constants, types, FSM states and popcount helper
//
// Purpose: common definitions for the CAM search-path encoder.
//   CAM_DEPTH / CAM_IDX_W : match-line count and index width
//   cam_match_t / cam_idx_t : match vector and index types
//   enc_state_e : encoder FSM states (IDLE, DRAIN)
//   popcount() : number of set bits in a match vector
package cam_pkg;

  localparam int CAM_DEPTH = 32;
  localparam int CAM_IDX_W = 5;

  typedef logic [CAM_DEPTH-1:0] cam_match_t;
  typedef logic [CAM_IDX_W-1:0] cam_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } enc_state_e;

  function automatic logic [CAM_IDX_W:0] popcount(input cam_match_t v);
    logic [CAM_IDX_W:0] n;
    n = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      n = n + {{CAM_IDX_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/priority_encoder_32_5.sv
// rtl/priority_encoder_32_5.sv - combinational lowest-set-bit encoder
//
// Purpose: returns the position of the lowest set bit of a 32-bit vector.
// Ports:
//   vec  in  32  input vector
//   idx  out 5   index of the lowest set bit (0 when vec is zero)
//   any  out 1   at least one bit of vec is set
module priority_encoder_32_5
  import cam_pkg::*;
(
  input  cam_match_t vec,
  output cam_idx_t   idx,
  output logic       any
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    idx = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = cam_idx_t'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - sequential 32-to-5 CAM match-line encoder
//
// Purpose: latches a CAM match vector and returns each hit index, lowest
// first, one per handshake; a search with no hits gives a one-cycle miss.
// Optional feature macro: CAM_MATCH_ENCODER_COUNT_EN (hit count output).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   search_valid_i  match_i valid this cycle (accepted only in IDLE)
//   match_i         raw match lines, bit k = entry k hit
//   busy_o          draining, searches ignored
//   idx_valid_o     idx_o holds a valid hit index
//   idx_o           lowest outstanding hit index
//   idx_last_o      idx_o is the final hit of the search
//   idx_ready_i     consumer accepts idx_o
//   miss_o          one-cycle pulse for a zero-hit search
//   match_count_o   popcount of the latched search (0 when feature off)
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter int WIDTH = CAM_DEPTH,
  parameter int IDX_W = CAM_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             search_valid_i,
  input  logic [WIDTH-1:0] match_i,
  output logic             busy_o,
  output logic             idx_valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_last_o,
  input  logic             idx_ready_i,
  output logic             miss_o,
  output logic [IDX_W:0]   match_count_o
);

  enc_state_e state;
  cam_match_t pending;
  cam_idx_t   enc_idx;
  logic       enc_any;
  logic       accept;
  logic       single_hit;

  priority_encoder_32_5 u_prio (
    .vec (pending),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign accept = (state == IDLE) && search_valid_i;

  // Clearing the lowest set bit leaves zero only when exactly one bit is set.
  assign single_hit = enc_any && ((pending & (pending - cam_match_t'(1))) == '0);

  assign busy_o      = (state == DRAIN);
  assign idx_valid_o = (state == DRAIN);
  assign idx_o       = enc_idx;
  assign idx_last_o  = (state == DRAIN) && single_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      miss_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miss_o <= accept && (match_i == '0);
          if (accept && (match_i != '0)) begin
            pending <= match_i;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          miss_o <= 1'b0;
          if (idx_ready_i) begin
            pending <= pending & ~(cam_match_t'(1) << enc_idx);
            if (single_hit) state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          miss_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAM_MATCH_ENCODER_COUNT_EN
  logic [IDX_W:0] count_q;

  // A miss also loads here, which naturally yields zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= popcount(match_i);
    end
  end

  assign match_count_o = count_q;
`else
  assign match_count_o = '0;
`endif

endmodule

// File: tb/tb_cam_match_encoder.sv
// tb/tb_cam_match_encoder.sv - self-checking bench for cam_match_encoder
module tb_cam_match_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        search_valid_i = 1'b0;
  logic [31:0] match_i = '0;
  logic        busy_o;
  logic        idx_valid_o;
  logic [4:0]  idx_o;
  logic        idx_last_o;
  logic        idx_ready_i = 1'b0;
  logic        miss_o;
  logic [5:0]  match_count_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  cam_match_encoder dut (
    .clk            (clk),
    .rst            (rst),
    .search_valid_i (search_valid_i),
    .match_i        (match_i),
    .busy_o         (busy_o),
    .idx_valid_o    (idx_valid_o),
    .idx_o          (idx_o),
    .idx_last_o     (idx_last_o),
    .idx_ready_i    (idx_ready_i),
    .miss_o         (miss_o),
    .match_count_o  (match_count_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ref_count(input logic [31:0] m);
    int n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n++;
`ifdef CAM_MATCH_ENCODER_COUNT_EN
    return 6'(n);
`else
    return 6'd0;
`endif
  endfunction

  // Outputs packed as {busy, valid, idx, last, miss, count}.
  function automatic logic [14:0] pack_out;
    return {busy_o, idx_valid_o, idx_o, idx_last_o, miss_o, match_count_o};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    step();
    total_cnt++;
    if (pack_out() !== 15'd0) $display("FAIL reset_outputs got=%h exp=0", pack_out());
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_hit;
    search_valid_i = 1'b1; match_i = 32'h0000_0100; idx_ready_i = 1'b1;
    step();
    search_valid_i = 1'b0;
    total_cnt++;
    if ({idx_valid_o, busy_o, idx_o, idx_last_o} !== {1'b1, 1'b1, 5'd8, 1'b1})
      $display("FAIL single_hit_idx got v=%b b=%b idx=%0d last=%b exp v=1 b=1 idx=8 last=1",
               idx_valid_o, busy_o, idx_o, idx_last_o);
    else pass_cnt++;
    total_cnt++;
    if (match_count_o !== ref_count(32'h100))
      $display("FAIL single_hit_count got=%0d exp=%0d", match_count_o, ref_count(32'h100));
    else pass_cnt++;
    step();
    total_cnt++;
    if ({busy_o, idx_valid_o} !== 2'b00)
      $display("FAIL single_hit_idle got busy=%b valid=%b exp 0 0", busy_o, idx_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_multi_hit;
    logic [4:0] exp_idx[3];
    exp_idx[0] = 5'd0; exp_idx[1] = 5'd2; exp_idx[2] = 5'd31;
    search_valid_i = 1'b1; match_i = 32'h8000_0005; idx_ready_i = 1'b1;
    step();
    search_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if ({idx_valid_o, idx_o, idx_last_o} !== {1'b1, exp_idx[k], k == 2})
        $display("FAIL multi_hit_seq%0d got v=%b idx=%0d last=%b exp v=1 idx=%0d last=%b",
                 k, idx_valid_o, idx_o, idx_last_o, exp_idx[k], k == 2);
      else pass_cnt++;
      total_cnt++;
      if (match_count_o !== ref_count(32'h8000_0005))
        $display("FAIL multi_hit_count got=%0d exp=%0d", match_count_o, ref_count(32'h8000_0005));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL multi_hit_idle got busy=%b exp 0", busy_o);
    else pass_cnt++;
  endtask

  task automatic test_miss;
    search_valid_i = 1'b1; match_i = 32'h0;
    step();
    search_valid_i = 1'b0;
    total_cnt++;
    if ({miss_o, idx_valid_o, busy_o, match_count_o} !== {1'b1, 1'b0, 1'b0, 6'd0})
      $display("FAIL miss_pulse got miss=%b v=%b busy=%b cnt=%0d exp 1 0 0 0",
               miss_o, idx_valid_o, busy_o, match_count_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({miss_o, idx_valid_o} !== 2'b00)
      $display("FAIL miss_one_cycle got miss=%b v=%b exp 0 0", miss_o, idx_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    search_valid_i = 1'b1; match_i = 32'h0000_0003; idx_ready_i = 1'b0;
    step();
    search_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({idx_valid_o, idx_o, idx_last_o} !== {1'b1, 5'd0, 1'b0})
        $display("FAIL bp_hold%0d got v=%b idx=%0d last=%b exp 1 0 0",
                 k, idx_valid_o, idx_o, idx_last_o);
      else pass_cnt++;
      search_valid_i = (k == 1);
      match_i = 32'h0000_0400;
      step();
      search_valid_i = 1'b0;
    end
    idx_ready_i = 1'b1;
    total_cnt++;
    if ({idx_o, idx_last_o} !== {5'd0, 1'b0})
      $display("FAIL bp_release got idx=%0d last=%b exp 0 0", idx_o, idx_last_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({idx_valid_o, idx_o, idx_last_o} !== {1'b1, 5'd1, 1'b1})
      $display("FAIL bp_second got v=%b idx=%0d last=%b exp 1 1 1", idx_valid_o, idx_o, idx_last_o);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if ({busy_o, idx_valid_o, miss_o} !== 3'b000)
      $display("FAIL bp_ignored_search got busy=%b v=%b miss=%b exp 0 0 0", busy_o, idx_valid_o, miss_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain;
    search_valid_i = 1'b1; match_i = 32'hFFFF_FFFF; idx_ready_i = 1'b1;
    step();
    search_valid_i = 1'b0;
    step(); step(); step();
    total_cnt++;
    if (idx_o !== 5'd3) $display("FAIL rst_pre_idx got=%0d exp=3", idx_o);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (pack_out() !== 15'd0) $display("FAIL rst_async got=%h exp=0", pack_out());
    else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    search_valid_i = 1'b1; match_i = 32'h10;
    step();
    search_valid_i = 1'b0;
    total_cnt++;
    if ({idx_valid_o, idx_o, idx_last_o} !== {1'b1, 5'd4, 1'b1})
      $display("FAIL rst_next_search got v=%b idx=%0d last=%b exp 1 4 1", idx_valid_o, idx_o, idx_last_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy_o !== 1'b0) $display("FAIL rst_next_done got busy=%b exp 0", busy_o);
    else pass_cnt++;
  endtask

  // Random searches checked against a queue of ascending hit positions.
  task automatic test_random;
    logic [31:0] m;
    int exp_q[$];
    int guard;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: m = 32'h0;
        1: m = 32'h1 << $urandom_range(0, 31);
        2: m = $urandom & $urandom & $urandom;
        default: m = $urandom;
      endcase
      exp_q.delete();
      for (int i = 0; i < 32; i++) if (m[i]) exp_q.push_back(i);
      search_valid_i = 1'b1; match_i = m;
      step();
      search_valid_i = 1'b0;
      total_cnt++;
      if (match_count_o !== ref_count(m) || miss_o !== (m == 0))
        $display("FAIL rand_accept t=%0d got cnt=%0d miss=%b exp cnt=%0d miss=%b",
                 t, match_count_o, miss_o, ref_count(m), m == 0);
      else pass_cnt++;
      guard = 0;
      while (exp_q.size() > 0 && guard < 300) begin
        guard++;
        total_cnt++;
        if ({idx_valid_o, busy_o, idx_o, idx_last_o} !== {1'b1, 1'b1, 5'(exp_q[0]), exp_q.size() == 1})
          $display("FAIL rand_drain t=%0d got v=%b idx=%0d last=%b exp v=1 idx=%0d last=%b",
                   t, idx_valid_o, idx_o, idx_last_o, exp_q[0], exp_q.size() == 1);
        else pass_cnt++;
        idx_ready_i = ($urandom_range(0, 9) < 7);
        search_valid_i = ($urandom_range(0, 7) == 0);
        match_i = $urandom;
        step();
        search_valid_i = 1'b0;
        if (idx_ready_i) void'(exp_q.pop_front());
      end
      total_cnt++;
      if (exp_q.size() != 0 || busy_o !== 1'b0 || idx_valid_o !== 1'b0)
        $display("FAIL rand_end t=%0d got busy=%b v=%b left=%0d exp 0 0 0",
                 t, busy_o, idx_valid_o, exp_q.size());
      else pass_cnt++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_miss();
    test_backpressure();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
